// File: rtl/sensor_acq_if.sv
// Bundles the scheduler's control inputs and status outputs between the surrounding system and
// the acquisition scheduler core.
interface sensor_acq_if #(
    parameter int N_CH    = 10,
    parameter int CNT_W   = 16,
    parameter int RATIO_W = 16,
    parameter int OVR_W   = 8
);
    // No valid/ready pairs: send_manual_trigger, event_qualifier and irq_clear are single-cycle
    // pulses that take effect on the edge they are high for; all other inputs are levels.
    logic                    do_auto_triggering;
    logic                    send_manual_trigger;
    logic                    event_qualifier;
    logic [RATIO_W-1:0]      user_ratio;
    logic [N_CH-1:0]         en_bits;
    logic [N_CH-1:0]         done;
    logic [CNT_W-1:0]        timeout_limit;
    logic                    irq_clear;
    logic [N_CH-1:0]         en;
    logic                    trigger;
    logic                    busy;
    logic                    sched_isr;
    logic                    timeout_flag;
    logic [N_CH-1:0]         timeout_ch;
    logic [CNT_W-1:0]        count_time;
    logic [N_CH*CNT_W-1:0]   ch_time;
    logic [OVR_W-1:0]        overrun_cnt;
    logic                    dbg_state;

    modport master (
        output do_auto_triggering, send_manual_trigger, event_qualifier, user_ratio,
               en_bits, done, timeout_limit, irq_clear,
        input  en, trigger, busy, sched_isr, timeout_flag, timeout_ch, count_time,
               ch_time, overrun_cnt, dbg_state
    );

    modport slave (
        input  do_auto_triggering, send_manual_trigger, event_qualifier, user_ratio,
               en_bits, done, timeout_limit, irq_clear,
        output en, trigger, busy, sched_isr, timeout_flag, timeout_ch, count_time,
               ch_time, overrun_cnt, dbg_state
    );
endinterface

// File: rtl/sensor_acq_scheduler.sv
// Acquisition scheduler: counts carrier events, issues sensor-start triggers (auto or manual),
// timestamps per-channel done edges and raises an interrupt on completion or timeout.
module sensor_acq_scheduler #(
    parameter int N_CH    = 10,
    parameter int CNT_W   = 16,
    parameter int RATIO_W = 16,
    parameter int OVR_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    sensor_acq_if.slave bus
);
    typedef enum logic {S_IDLE = 1'b0, S_ACQ = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [RATIO_W-1:0]    r_evt_cnt;
    logic                  r_queue;
    logic [N_CH-1:0]       r_done_ff;
    logic [N_CH-1:0]       r_captured;
    logic [N_CH-1:0]       r_en;
    logic [N_CH-1:0]       r_timeout_ch;
    logic                  r_trigger;
    logic                  r_isr;
    logic                  r_timeout_flag;
    logic [CNT_W-1:0]      r_count_time;
    logic [N_CH*CNT_W-1:0] r_ch_time;
    logic [OVR_W-1:0]      r_overrun;

    logic                  w_ratio_hit;
    logic                  w_in_acq;
    logic                  w_fire;
    logic                  w_complete;
    logic                  w_timeout;
    logic [N_CH-1:0]       w_rise;
    logic [N_CH-1:0]       w_cap;

    assign w_ratio_hit = bus.event_qualifier & (r_evt_cnt == bus.user_ratio);
    assign w_in_acq    = (r_state == S_ACQ);
    assign w_rise      = bus.done & ~r_done_ff;
    assign w_cap       = w_rise & r_en & ~r_captured & {N_CH{w_in_acq}};

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // With no channel enabled nothing fires and a pending manual request is kept.
                if ((|bus.en_bits) &&
                    ((bus.do_auto_triggering && w_ratio_hit) || (r_queue && bus.event_qualifier))) begin
                    w_fire      = 1'b1;
                    w_state_nxt = S_ACQ;
                end
            end
            S_ACQ: begin
                w_complete = (((r_captured | (w_rise & r_en)) & r_en) == r_en);
                w_timeout  = !w_complete && (bus.timeout_limit != '0) &&
                             (r_count_time == bus.timeout_limit);
                if (w_complete || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_evt_cnt      <= '0;
            r_queue        <= 1'b0;
            r_done_ff      <= '0;
            r_captured     <= '0;
            r_en           <= '0;
            r_timeout_ch   <= '0;
            r_trigger      <= 1'b0;
            r_isr          <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_count_time   <= '0;
            r_ch_time      <= '0;
            r_overrun      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done_ff <= bus.done;
            r_trigger <= w_fire;
            r_queue   <= bus.send_manual_trigger | (r_queue & ~w_fire);
            r_isr     <= w_complete | w_timeout | (r_isr & ~bus.irq_clear);

            if (w_ratio_hit) begin
                r_evt_cnt <= '0;
            end else if (bus.event_qualifier) begin
                r_evt_cnt <= r_evt_cnt + RATIO_W'(1);
            end

            if (w_fire) begin
                r_count_time <= '0;
            end else if (r_count_time != '1) begin
                r_count_time <= r_count_time + CNT_W'(1);
            end

            if (w_fire) begin
                r_en           <= bus.en_bits;
                r_captured     <= '0;
                r_timeout_flag <= 1'b0;
                r_timeout_ch   <= '0;
            end else begin
                r_captured <= r_captured | w_cap;
                if (w_timeout) begin
                    r_timeout_flag <= 1'b1;
                    r_timeout_ch   <= r_en & ~r_captured;
                end
            end

            for (int i = 0; i < N_CH; i++) begin
                if (w_cap[i]) begin
                    r_ch_time[i*CNT_W +: CNT_W] <= r_count_time;
                end
            end

            // Auto ratio hits that arrive mid-acquisition are dropped and only counted.
            if (w_in_acq && bus.do_auto_triggering && w_ratio_hit && (r_overrun != '1)) begin
                r_overrun <= r_overrun + OVR_W'(1);
            end
        end
    end

    assign bus.en           = r_en;
    assign bus.trigger      = r_trigger;
    assign bus.busy         = w_in_acq;
    assign bus.sched_isr    = r_isr;
    assign bus.timeout_flag = r_timeout_flag;
    assign bus.timeout_ch   = r_timeout_ch;
    assign bus.count_time   = r_count_time;
    assign bus.ch_time      = r_ch_time;
    assign bus.overrun_cnt  = r_overrun;
    assign bus.dbg_state    = r_state;
endmodule
